// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I pipeline constants and IF/ID entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int                c_XLEN = 32;
    localparam logic [c_XLEN-1:0] c_NOP  = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] instr;
    } if_id_entry_t;

    function automatic if_id_entry_t make_entry(input logic [c_XLEN-1:0] pc,
                                                input logic [c_XLEN-1:0] instr);
        if_id_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_storage.sv
// ============================================================================
// Module      : if_id_storage
// Description : DEPTH x WIDTH register array, one write port, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are never reset; validity lives in the owning queue.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
// Module      : if_id_buffer
// Description : Fetch-to-decode queue with flush; DEPTH=1 is a stallable IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer
    import rv_pkg::*;
#(
    parameter int               DEPTH = 4,
    parameter int               XLEN  = c_XLEN,
    parameter logic [XLEN-1:0]  NOP   = XLEN'(c_NOP)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_IF,
    input  logic [XLEN-1:0] INSTRUCTION_IF,
    input  logic            IF_valid,
    input  logic            PCSrc,
    input  logic            ID_stall,
    output logic            PC_write,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] INSTRUCTION_ID,
    output logic            ID_valid
);

    localparam int              AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW     = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   c_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   c_FULL = CW'(DEPTH);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_head;

    // Ready is a pure function of registered count, so fetch sees no input path.
    assign w_valid  = (r_count != '0);
    assign PC_write = (r_count != c_FULL);
    assign w_push   = IF_valid & PC_write & ~PCSrc;
    assign w_pop    = w_valid & ~ID_stall;

    always_ff @(posedge clk) begin
        if (!reset || PCSrc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    if_id_storage #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data ({PC_IF, INSTRUCTION_IF}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    assign ID_valid       = w_valid;
    assign PC_ID          = w_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign INSTRUCTION_ID = w_valid ? w_head[XLEN-1:0]      : NOP;

endmodule

`default_nettype wire
